// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_if
// Description : Beat stream (field-level instruction descriptions) into the
//               encoder/loader, plus its single IMEM write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    // Field-level instruction beat
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;

    // IMEM write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Producer of beats / consumer of the IMEM writes
    modport master (
        output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    // The encoder/loader itself
    modport slave (
        input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Encodes field-level RV32I instruction descriptions into 32-bit
//               words and writes them sequentially into IMEM. Illegal beats
//               are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic [ADDR_W-1:0] base_addr,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   err,
    output logic [7:0]             err_count
);

    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [7:0]        err_count_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;

    logic              w_ready;
    logic              w_hs;
    logic              w_legal;
    logic [31:0]       w_word;
    logic              w_fits12;
    logic              w_fits13;
    logic              w_fits21;
    logic              w_shamt_ok;
    logic [31:0]       w_imm;
    logic [2:0]        w_f3;

    assign w_imm = bus.in_imm;
    assign w_f3  = bus.in_funct3;

    // Range checks on the sign-extended immediate: every bit above the field's
    // sign bit must replicate it.
    assign w_fits12   = (w_imm[31:11] == {21{w_imm[11]}});
    assign w_fits13   = (w_imm[31:12] == {20{w_imm[12]}});
    assign w_fits21   = (w_imm[31:20] == {12{w_imm[20]}});
    assign w_shamt_ok = (w_imm[31:5] == 27'd0);

    // Beats are only taken in RUN and never in a cycle that restarts or ends the session
    assign w_ready      = (state_q == S_RUN) && !start && !stop;
    assign w_hs         = bus.in_valid && w_ready;
    assign bus.in_ready = w_ready;

    // Field assembly and legality of the offered beat
    always_comb begin
        w_legal = 1'b0;
        w_word  = 32'd0;
        case (bus.in_class)
            4'd0: begin
                w_legal = !bus.in_alt || (w_f3 == 3'b000) || (w_f3 == 3'b101);
                w_word  = {1'b0, bus.in_alt, 5'b0, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, c_OP_R};
            end
            4'd1: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    // Shift-immediate: alt selects SRAI, which has no left-shift counterpart
                    w_legal = w_shamt_ok && !((w_f3 == 3'b001) && bus.in_alt);
                    w_word  = {1'b0, bus.in_alt, 5'b0, w_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, c_OP_IMM};
                end else begin
                    w_legal = w_fits12;
                    w_word  = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, c_OP_IMM};
                end
            end
            4'd2: begin
                w_legal = w_fits12;
                w_word  = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, c_OP_LOAD};
            end
            4'd3: begin
                w_legal = w_fits12;
                w_word  = {w_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:0], c_OP_STORE};
            end
            4'd4: begin
                w_legal = w_fits13 && !w_imm[0] && (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_word  = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3,
                           w_imm[4:1], w_imm[11], c_OP_BRANCH};
            end
            4'd5: begin
                w_legal = w_fits21 && !w_imm[0];
                w_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, c_OP_JAL};
            end
            4'd6: begin
                w_legal = w_fits12 && (w_f3 == 3'b000);
                w_word  = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, c_OP_JALR};
            end
            4'd7: begin
                w_legal = (w_imm[11:0] == 12'd0);
                w_word  = {w_imm[31:12], bus.in_rd, c_OP_LUI};
            end
            4'd8: begin
                w_legal = (w_imm[11:0] == 12'd0);
                w_word  = {w_imm[31:12], bus.in_rd, c_OP_AUIPC};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = 32'd0;
            end
        endcase
    end

    // Session state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start overrides everything, including a simultaneous stop
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (w_hs && w_legal && ((count_q + c_CNT_ONE) == c_DEPTH)) begin
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write stage, session counters and error bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            err_count_q  <= 8'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
        end else begin
            imem_we_q <= 1'b0;
            if (start) begin
                wr_ptr_q    <= base_addr;
                count_q     <= '0;
                err_q       <= 1'b0;
                err_count_q <= 8'd0;
            end else if (w_hs) begin
                if (w_legal) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= wr_ptr_q;
                    imem_wdata_q <= w_word;
                    wr_ptr_q     <= wr_ptr_q + c_PTR_ONE;
                    count_q      <= count_q + c_CNT_ONE;
                end else begin
                    err_q <= 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign full           = (count_q == c_DEPTH);
    assign count          = count_q;
    assign err            = err_q;
    assign err_count      = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Directed and randomized bench for instr_encoder_loader with a
//               behavioural encoding/session model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam int AW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy;
    logic          full;
    logic [AW:0]   count;
    logic          err;
    logic [7:0]    err_count;

    instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .full      (full),
        .count     (count),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Behavioural model: 0 idle, 1 running, 2 full
    int          m_state = 0;
    int          m_ptr = 0;
    int          m_count = 0;
    int          m_errcnt = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    int          m_addr = 0;
    logic [31:0] m_wdata = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoder written from the ISA field layouts, using integer ranges
    function automatic void ref_encode(input int cls, input logic [2:0] f3, input bit alt,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm,
                                       output bit ok, output logic [31:0] w);
        int          si;
        logic [31:0] rrr, ii, ss;
        si  = imm;
        rrr = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        ii  = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        ss  = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        ok  = 0;
        w   = 0;
        case (cls)
            0: begin
                ok = !alt || f3 == 0 || f3 == 5;
                w  = (32'(alt) << 30) | rrr | 32'h33;
            end
            1: begin
                if (f3 == 1 || f3 == 5) begin
                    ok = (si >= 0) && (si <= 31) && !(f3 == 1 && alt);
                    w  = (32'(alt) << 30) | (fld(imm, 0, 5) << 20) | ii | 32'h13;
                end else begin
                    ok = (si >= -2048) && (si <= 2047);
                    w  = (fld(imm, 0, 12) << 20) | ii | 32'h13;
                end
            end
            2: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = (fld(imm, 0, 12) << 20) | ii | 32'h03;
            end
            3: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = (fld(imm, 5, 7) << 25) | ss | (fld(imm, 0, 5) << 7) | 32'h23;
            end
            4: begin
                ok = (f3 != 2) && (f3 != 3) && (si % 2 == 0) && (si >= -4096) && (si <= 4094);
                w  = (fld(imm, 12, 1) << 31) | (fld(imm, 5, 6) << 25) | ss |
                     (fld(imm, 1, 4) << 8) | (fld(imm, 11, 1) << 7) | 32'h63;
            end
            5: begin
                ok = (si % 2 == 0) && (si >= -1048576) && (si <= 1048574);
                w  = (fld(imm, 20, 1) << 31) | (fld(imm, 1, 10) << 21) | (fld(imm, 11, 1) << 20) |
                     (fld(imm, 12, 8) << 12) | (32'(rd) << 7) | 32'h6F;
            end
            6: begin
                ok = (f3 == 0) && (si >= -2048) && (si <= 2047);
                w  = (fld(imm, 0, 12) << 20) | ii | 32'h67;
            end
            7, 8: begin
                ok = (si % 4096 == 0);
                w  = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | ((cls == 7) ? 32'h37 : 32'h17);
            end
            default: begin
                ok = 0;
                w  = 0;
            end
        endcase
    endfunction

    task automatic check_outputs();
        chk("imem_we",    32'(bus.imem_we),   32'(m_we));
        chk("imem_addr",  32'(bus.imem_addr), 32'(m_addr));
        chk("imem_wdata", bus.imem_wdata,     m_wdata);
        chk("count",      32'(count),         32'(m_count));
        chk("full",       32'(full),          32'(m_count == DP));
        chk("busy",       32'(busy),          32'(m_state != 0));
        chk("err",        32'(err),           32'(m_err));
        chk("err_count",  32'(err_count),     32'(m_errcnt));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs
    task automatic step(input bit st, input bit sp, input bit v, input logic [3:0] cls,
                        input logic [2:0] f3, input bit alt, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bit          rdy, hs, ok;
        logic [31:0] w;
        start         = st;
        stop          = sp;
        bus.in_valid  = v;
        bus.in_class  = cls;
        bus.in_funct3 = f3;
        bus.in_alt    = alt;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        #1;
        rdy = (m_state == 1) && !st && !sp;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        hs = v && rdy;
        ref_encode(int'(cls), f3, alt, rd, rs1, rs2, imm, ok, w);
        @(posedge clk);
        m_we = 0;
        if (st) begin
            m_state  = 1;
            m_ptr    = int'(base_addr);
            m_count  = 0;
            m_err    = 0;
            m_errcnt = 0;
        end else begin
            if (hs && ok) begin
                m_we    = 1;
                m_addr  = m_ptr;
                m_wdata = w;
                m_ptr   = (m_ptr + 1) % (1 << AW);
                m_count = m_count + 1;
                if (m_count == DP) m_state = 2;
            end else if (hs) begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
            end
            if (sp) m_state = 0;
        end
        #1;
        check_outputs();
        start        = 0;
        stop         = 0;
        bus.in_valid = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset        = 1;
        bus.in_valid = 1;
        bus.in_class = 4'd1;
        bus.in_imm   = 32'd3;
        @(posedge clk);
        #1;
        reset        = 0;
        bus.in_valid = 0;
        m_state = 0; m_ptr = 0; m_count = 0; m_errcnt = 0;
        m_err = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [14];
        edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094, 32'd4095,
                  32'hFFFF_F000, 32'hFFFF_EFFE, 32'd1048574, 32'd1048576, 32'hFFF0_0000,
                  32'd31, 32'd32, 32'h1234_5000};
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 40));
            1: return 32'(-int'($urandom_range(0, 40)));
            2: return edges[$urandom_range(0, 13)];
            3: return $urandom & 32'hFFFF_F000;
            4: return $urandom;
            default: return 32'($urandom_range(0, 8190)) - 32'd4096;
        endcase
    endfunction

    initial begin
        bus.in_valid = 0; bus.in_class = 0; bus.in_funct3 = 0; bus.in_alt = 0;
        bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;

        do_reset();
        idle();

        // Session at 0x10: OP-IMM addi x1, x0, 5
        base_addr = 8'h10;
        step(1, 0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(0, 0, 1, 4'd1, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("tp_addi_wdata", bus.imem_wdata, 32'h0050_0093);
        chk("tp_addi_addr",  32'(bus.imem_addr), 32'h10);

        // SUB then BRANCH back to back
        step(0, 0, 1, 4'd0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("tp_sub_wdata", bus.imem_wdata, 32'h4020_81B3);
        step(0, 0, 1, 4'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        chk("tp_beq_wdata", bus.imem_wdata, 32'hFE20_8CE3);
        chk("tp_beq_addr",  32'(bus.imem_addr), 32'h12);

        // New session: JAL and LUI at consecutive addresses
        base_addr = 8'h30;
        step(1, 0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(0, 0, 1, 4'd5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048);
        chk("tp_jal_wdata", bus.imem_wdata, 32'h0010_00EF);
        step(0, 0, 1, 4'd7, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        chk("tp_lui_wdata", bus.imem_wdata, 32'h1234_52B7);
        chk("tp_lui_addr",  32'(bus.imem_addr), 32'h31);

        // Three illegal beats, then a legal one at the unchanged address
        step(0, 0, 1, 4'd1, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step(0, 0, 1, 4'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd3);
        step(0, 0, 1, 4'd12, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("tp_ill_errcnt", 32'(err_count), 32'd3);
        chk("tp_ill_count",  32'(count), 32'd2);
        step(0, 0, 1, 4'd2, 3'd2, 0, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFC);
        chk("tp_ill_next_addr", 32'(bus.imem_addr), 32'h32);

        // Wrap at the top of IMEM and fill the session
        base_addr = 8'd254;
        step(1, 0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 4'd1, 3'd0, 0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            if (i < 4) chk("tp_wrap_addr", 32'(bus.imem_addr), 32'((254 + i) % 256));
        end
        chk("tp_full", 32'(full), 32'd1);
        chk("tp_full_ready", 32'(bus.in_ready), 32'd0);
        step(0, 1, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("tp_stop_busy", 32'(busy), 32'd0);

        // start during RUN with a valid beat, then stop right after an acceptance
        base_addr = 8'h40;
        step(1, 0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(0, 0, 1, 4'd3, 3'd2, 0, 5'd0, 5'd4, 5'd5, 32'd12);
        base_addr = 8'h50;
        step(1, 0, 1, 4'd1, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd1);
        chk("tp_restart_count", 32'(count), 32'd0);
        step(0, 0, 1, 4'd6, 3'd0, 0, 5'd1, 5'd2, 5'd0, 32'd16);
        chk("tp_restart_addr", 32'(bus.imem_addr), 32'h50);
        step(0, 1, 1, 4'd6, 3'd0, 0, 5'd1, 5'd2, 5'd0, 32'd16);
        step(1, 0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(0, 0, 1, 4'd8, 3'd0, 0, 5'd9, 5'd0, 5'd0, 32'hABCD_E000);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            bit          st, sp, v, a;
            logic [3:0]  c;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 24) == 0) || (m_state != 1 && $urandom_range(0, 3) == 0);
                sp = ($urandom_range(0, 29) == 0);
                v  = ($urandom_range(0, 9) < 7);
                a  = ($urandom_range(0, 3) == 0);
                c  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
                base_addr = 8'($urandom);
                step(st, sp, v, c, 3'($urandom), a, 5'($urandom), 5'($urandom), 5'($urandom),
                     rand_imm());
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the ID-stage decoder: takes field-level instruction descriptions (class, funct3, alt bit, rd/rs1/rs2, 32-bit immediate) over a valid/ready stream.
- Assembles each into a 32-bit RV32I word and writes it sequentially into instruction memory through a single write port.
- Used by the test/boot infrastructure to load programs into the pipeline CPU's IMEM. Range and alignment checks drop illegal entries and count them.

Parameters:
- ADDR_W, 8, IMEM word-address width.
- DEPTH, 256, maximum instructions per load session; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse: begin session, load base_addr, clear count/err.
- stop  input  1  one-cycle pulse: end session, return to IDLE.
- base_addr  input  ADDR_W  first IMEM word address of the session.
- in_valid  input  1  instruction beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_class  input  4  0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9–15 illegal.
- in_funct3  input  3  funct3 field.
- in_alt  input  1  instruction bit 30 (SUB/SRA/SRAI).
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_imm  input  32  signed immediate/offset as full value (LUI/AUIPC: full 32-bit value).
- imem_we  output  1  IMEM write strobe.
- imem_addr  output  ADDR_W  IMEM word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  state != IDLE.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  instructions written this session.
- err  output  1  sticky: at least one beat rejected this session.
- err_count  output  8  rejected beats; saturates at 255.

Behaviour:
- Reset: state IDLE; in_ready, imem_we, full, err = 0; imem_addr, imem_wdata, count, err_count, internal wr_ptr = 0.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; accepted valid beat making count == DEPTH -> FULL.
  - FULL: stop -> IDLE.
  - start in any state -> RUN, reinitialising the session. start beats stop when both are asserted.
- Session init on start: wr_ptr <= base_addr, count <= 0, err <= 0, err_count <= 0.
- in_ready = (state == RUN) && !start && !stop (combinational). Handshake = in_valid && in_ready. Beats offered with in_ready = 0 are ignored, never buffered.
- Accepted beat, one registered stage; result visible the cycle after the handshake:
  - If legal: imem_we <= 1, imem_addr <= wr_ptr, imem_wdata <= encoding, wr_ptr <= wr_ptr + 1 (modulo 2^ADDR_W wrap), count <= count + 1.
  - If illegal: imem_we <= 0, err <= 1, err_count <= err_count + 1 (saturating); wr_ptr and count unchanged.
- imem_we is 0 in every cycle not following a legal accepted beat.
- Throughput is one beat per cycle.
- Encoding (opcodes per the ISA; R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111):
  - R: {1'b0, in_alt, 5'b0, rs2, rs1, f3, rd, op}.
    - in_alt is legal only with f3 000 or 101.
  - OP-IMM:
    - f3 001: shift; imm 0..31 required; bit30 = in_alt; in_alt = 1 is illegal.
    - f3 101: shift; imm 0..31 required; bit30 = in_alt.
    - Other f3: imm[11:0] with range -2048..2047; in_alt ignored.
  - LOAD, JALR: I-format with imm range -2048..2047. JALR requires f3 = 000.
  - STORE: S-format {imm[11:5], rs2, rs1, f3, imm[4:0], op}, range -2048..2047.
  - BRANCH: B-format, imm even, range -4096..4094; f3 010/011 illegal.
  - JAL: J-format {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}, imm even, range -1048576..1048574.
  - LUI/AUIPC: {imm[31:12], rd, op}; imm[11:0] must be 0.
  - Class ≥ 9: illegal.
- Outputs written in FULL or IDLE hold their last values. A stop/start in the cycle after an acceptance does not cancel that pending write.
- reset mid-session: immediate return to reset values; the pending write is lost.

Test Plan:
- start (base 0x10), then OP-IMM f3=0 rd=1 rs1=0 imm=5 -> next cycle imem_we=1, addr=0x10, wdata=0x00500093, count=1.
- R f3=0 alt=1 rd=3 rs1=1 rs2=2, then BRANCH f3=0 rs1=1 rs2=2 imm=-8, back to back -> wdata 0x402081B3 at addr 0x11, then 0xFE208CE3 at addr 0x12, one per cycle.
- JAL rd=1 imm=2048 -> 0x001000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7. Both written at consecutive addresses.
- OP-IMM imm=2048; BRANCH imm=3; class 12 -> no imem_we, err=1, err_count=3, count unchanged. Next legal beat is written at the unchanged address.
- DEPTH=4, base=2^ADDR_W-2, 5 legal beats with in_valid held high -> writes at addresses 254, 255, 0, 1; full=1; in_ready=0; fifth beat not accepted. stop -> busy=0.
- start asserted with in_valid=1 during RUN -> in_ready=0 that cycle, no write. Next cycle count=0 and wr_ptr=base_addr. reset asserted mid-stream -> all outputs zero next cycle.
